// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGBW command controller and the PWM channel blocks:
// opcodes, channel indices and controller state encoding.
package rgbw_pkg;

  localparam int NUM_CH = 5;

  // Channel indices into the active and shadow banks.
  localparam logic [2:0] CH_R = 3'd0;
  localparam logic [2:0] CH_G = 3'd1;
  localparam logic [2:0] CH_B = 3'd2;
  localparam logic [2:0] CH_W = 3'd3;
  localparam logic [2:0] CH_I = 3'd4;

  // Command opcodes. WRITE_ONE carries the channel index in bits [2:0].
  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_WRITE_ALL = 8'h10;
  localparam logic [7:0] OP_WRITE_ONE = 8'h20;

  // Payload lengths in bytes.
  localparam logic [2:0] LEN_NOP = 3'd0;
  localparam logic [2:0] LEN_ALL = 3'd5;
  localparam logic [2:0] LEN_ONE = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  typedef logic [7:0] chan_bank_t [NUM_CH];

endpackage

// File: rtl/rgbw_cmd_ctrl.sv
// Command-frame controller: parses command/payload/checksum from the SPI byte
// stream into a shadow bank and commits it to the active channel registers only
// when the XOR checksum matches. Aborted or corrupt frames leave outputs alone.
module rgbw_cmd_ctrl
  import rgbw_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       byte_rdy,
  input  logic [7:0] byte_in,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] white,
  output logic [7:0] intensity,
  output logic       update,
  output logic       err,
  output logic       busy
);

  state_t     r_state, w_state;
  logic [2:0] r_cnt, w_cnt;
  logic [2:0] r_len, w_len;
  logic [2:0] r_base, w_base;
  logic [7:0] r_acc, w_acc;
  logic [4:0] r_mask, w_mask;
  logic       r_update, w_update;
  logic       r_err, w_err;
  chan_bank_t r_shadow, w_shadow;
  chan_bank_t r_active, w_active;
  logic [2:0] w_tgt;

  // WRITE_ALL walks channels 0..4 from base 0; WRITE_ONE uses its channel as base.
  assign w_tgt = r_base + r_cnt;

  // State and datapath registers; reset returns everything to its idle value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_len    <= 3'd0;
      r_base   <= 3'd0;
      r_acc    <= 8'h00;
      r_mask   <= 5'd0;
      r_update <= 1'b0;
      r_err    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= 8'h00;
        r_active[i] <= RST_VAL;
      end
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_len    <= w_len;
      r_base   <= w_base;
      r_acc    <= w_acc;
      r_mask   <= w_mask;
      r_update <= w_update;
      r_err    <= w_err;
      r_shadow <= w_shadow;
      r_active <= w_active;
    end
  end

  // Next-state, frame parsing and commit; cs high overrides any byte strobe.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_len    = r_len;
    w_base   = r_base;
    w_acc    = r_acc;
    w_mask   = r_mask;
    w_update = 1'b0;
    w_err    = 1'b0;
    w_shadow = r_shadow;
    w_active = r_active;

    if (cs) begin
      w_state = ST_IDLE;
      w_cnt   = 3'd0;
      w_acc   = 8'h00;
      w_mask  = 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state = ST_CMD;
          w_cnt   = 3'd0;
          w_acc   = 8'h00;
          w_mask  = 5'd0;
        end
        ST_CMD: begin
          if (byte_rdy) begin
            w_acc  = byte_in;
            w_cnt  = 3'd0;
            w_mask = 5'd0;
            if (byte_in == OP_NOP) begin
              w_len   = LEN_NOP;
              w_base  = CH_R;
              w_state = ST_CHECK;
            end else if (byte_in == OP_WRITE_ALL) begin
              w_len   = LEN_ALL;
              w_base  = CH_R;
              w_state = ST_PAYLOAD;
            end else if ((byte_in[7:3] == OP_WRITE_ONE[7:3]) && (byte_in[2:0] <= CH_I)) begin
              w_len   = LEN_ONE;
              w_base  = byte_in[2:0];
              w_state = ST_PAYLOAD;
            end else begin
              w_err   = 1'b1;
              w_state = ST_DRAIN;
            end
          end else begin
            w_state = ST_CMD;
          end
        end
        ST_PAYLOAD: begin
          if (byte_rdy) begin
            if (w_tgt <= CH_I) begin
              w_shadow[w_tgt] = byte_in;
              w_mask[w_tgt]   = 1'b1;
            end else begin
              w_mask = r_mask;
            end
            w_acc = r_acc ^ byte_in;
            w_cnt = r_cnt + 3'd1;
            if ((r_cnt + 3'd1) == r_len) begin
              w_state = ST_CHECK;
            end else begin
              w_state = ST_PAYLOAD;
            end
          end else begin
            w_state = ST_PAYLOAD;
          end
        end
        ST_CHECK: begin
          if (byte_rdy) begin
            if (byte_in == r_acc) begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (r_mask[i]) begin
                  w_active[i] = r_shadow[i];
                end else begin
                  w_active[i] = r_active[i];
                end
              end
              w_update = |r_mask;
              w_mask   = 5'd0;
              w_state  = ST_CMD;
            end else begin
              w_err   = 1'b1;
              w_state = ST_DRAIN;
            end
          end else begin
            w_state = ST_CHECK;
          end
        end
        ST_DRAIN: begin
          w_state = ST_DRAIN;
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  assign red       = r_active[CH_R];
  assign green     = r_active[CH_G];
  assign blue      = r_active[CH_B];
  assign white     = r_active[CH_W];
  assign intensity = r_active[CH_I];
  assign update    = r_update;
  assign err       = r_err;
  assign busy      = (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);

endmodule
